// File: rtl/reg_debug_port.sv
// Debug command port that borrows the core's register-file write and read-1 ports.
// Handles single reads/writes and four-register dumps with response backpressure.
package reg_debug_port_pkg;
    typedef enum logic [1:0] {
        REG_SEL_0 = 2'd0,
        REG_SEL_1 = 2'd1,
        REG_SEL_2 = 2'd2,
        REG_SEL_3 = 2'd3
    } register_sel_e;

    typedef enum logic {
        REG_NOP   = 1'b0,
        REG_WRITE = 1'b1
    } registers_op_e;
endpackage

// state   | meaning
// IDLE    | accepting a command, ports released
// ACQUIRE | requesting ownership, waiting for dbg_gnt
// EXEC    | single access cycle on the register file
// RESP    | response offered, waiting for rsp_ready
module reg_debug_port
    import reg_debug_port_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic                      cmd_dump,
    input  register_sel_e             cmd_index,
    input  logic [DATA_BUS_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output register_sel_e             rsp_index,
    output logic [DATA_BUS_WIDTH-1:0] rsp_data,
    output logic                      rsp_last,
    output logic                      dbg_req,
    input  logic                      dbg_gnt,
    output registers_op_e             op,
    output register_sel_e             reg_in_sel,
    output logic [DATA_BUS_WIDTH-1:0] reg_data_in,
    output register_sel_e             reg_1_out_sel,
    input  logic [DATA_BUS_WIDTH-1:0] reg_1_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        EXEC    = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic                        write_q, write_d;
    logic                        dump_q, dump_d;
    register_sel_e               idx_q, idx_d;
    logic [DATA_BUS_WIDTH-1:0]   wdata_q, wdata_d;
    register_sel_e               rsp_index_q, rsp_index_d;
    logic [DATA_BUS_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                        rsp_last_q, rsp_last_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            dump_q      <= 1'b0;
            idx_q       <= REG_SEL_0;
            wdata_q     <= '0;
            rsp_index_q <= REG_SEL_0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            dump_q      <= dump_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rsp_index_q <= rsp_index_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        dump_d        = dump_q;
        idx_d         = idx_q;
        wdata_d       = wdata_q;
        rsp_index_d   = rsp_index_q;
        rsp_data_d    = rsp_data_q;
        rsp_last_d    = rsp_last_q;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        dbg_req       = 1'b0;
        op            = REG_NOP;
        reg_in_sel    = REG_SEL_0;
        reg_data_in   = '0;
        reg_1_out_sel = REG_SEL_0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // A dump is always a read sweep starting from register 0
                    write_d = cmd_dump ? 1'b0 : cmd_write;
                    dump_d  = cmd_dump;
                    idx_d   = cmd_dump ? REG_SEL_0 : cmd_index;
                    wdata_d = cmd_wdata;
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE: begin
                dbg_req = 1'b1;
                if (dbg_gnt) state_d = EXEC;
            end
            EXEC: begin
                dbg_req = 1'b1;
                if (!dbg_gnt) begin
                    state_d = ACQUIRE;
                end else begin
                    if (write_q) begin
                        op          = REG_WRITE;
                        reg_in_sel  = idx_q;
                        reg_data_in = wdata_q;
                        rsp_data_d  = wdata_q;
                    end else begin
                        reg_1_out_sel = idx_q;
                        rsp_data_d    = reg_1_out;
                    end
                    rsp_index_d = idx_q;
                    rsp_last_d  = !dump_q || (idx_q == REG_SEL_3);
                    state_d     = RESP;
                end
            end
            RESP: begin
                dbg_req   = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (dump_q && (idx_q != REG_SEL_3)) begin
                        idx_d   = register_sel_e'(idx_q + 2'd1);
                        state_d = dbg_gnt ? EXEC : ACQUIRE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_index = rsp_index_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_reg_debug_port.sv
// Scoreboard bench for reg_debug_port with a behavioural register-file core model.
module tb_reg_debug_port;
    import reg_debug_port_pkg::*;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_dump;
    register_sel_e cmd_index;
    logic [7:0]    cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_last;
    register_sel_e rsp_index;
    logic [7:0]    rsp_data;
    logic          dbg_req, dbg_gnt;
    registers_op_e op;
    register_sel_e reg_in_sel, reg_1_out_sel;
    logic [7:0]    reg_data_in, reg_1_out;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rf[4];
    int         write_cnt = 0;
    int         vectors = 0;
    int         miscompares = 0;

    reg_debug_port #(.DATA_BUS_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_dump(cmd_dump), .cmd_index(cmd_index), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_index(rsp_index),
        .rsp_data(rsp_data), .rsp_last(rsp_last),
        .dbg_req(dbg_req), .dbg_gnt(dbg_gnt), .op(op),
        .reg_in_sel(reg_in_sel), .reg_data_in(reg_data_in),
        .reg_1_out_sel(reg_1_out_sel), .reg_1_out(reg_1_out)
    );

    always #5 clock = ~clock;

    // Core register file: write lands at the edge, read port is combinational
    always @(posedge clock) begin
        if (op == REG_WRITE) begin
            rf[reg_in_sel] <= reg_data_in;
            write_cnt      <= write_cnt + 1;
        end
    end
    assign reg_1_out = rf[reg_1_out_sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: a handshake will occur at the next rising edge
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            exp_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: got idx=%0d data=%0h last=%0b expected none",
                         rsp_index, rsp_data, rsp_last);
            end else begin
                e = exp_q.pop_front();
                if ({2'(rsp_index), rsp_data, rsp_last} !== e) begin
                    miscompares++;
                    $display("FAIL rsp: got idx=%0d data=%0h last=%0b expected idx=%0d data=%0h last=%0b",
                             rsp_index, rsp_data, rsp_last, e.idx, e.data, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic wr, input logic dmp, input logic [1:0] idx, input logic [7:0] d);
        bit done = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_dump  = dmp;
        cmd_index = register_sel_e'(idx);
        cmd_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            done = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    task automatic wait_rsp_valid();
        for (int i = 0; i < 50 && !rsp_valid; i++) tick();
        check("rsp_valid_wait", rsp_valid, 1);
    endtask

    int w0;

    initial begin
        reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_dump = 0;
        cmd_index = REG_SEL_0; cmd_wdata = 0; rsp_ready = 1; dbg_gnt = 1;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        #2;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_dbg_req", dbg_req, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_op", op, REG_NOP);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Write then read with latency check
        issue(1, 0, 2, 8'hA5);
        exp_q.push_back('{2'd2, 8'hA5, 1'b1});
        wait_drain();
        issue(0, 0, 2, 8'h00);
        exp_q.push_back('{2'd2, 8'hA5, 1'b1});
        check("lat_acquire", rsp_valid, 0);
        tick();
        check("lat_exec", rsp_valid, 0);
        tick();
        check("lat_resp", rsp_valid, 1);
        wait_drain();

        // Preload for dump
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 2'(i), 8'(8'h11 * (i + 1)));
            exp_q.push_back('{2'(i), 8'(8'h11 * (i + 1)), 1'b1});
            wait_drain();
        end

        // Grant stall
        dbg_gnt = 0;
        issue(0, 0, 1, 8'h00);
        exp_q.push_back('{2'd1, 8'h22, 1'b1});
        for (int i = 0; i < 5; i++) begin
            check("stall_dbg_req", dbg_req, 1);
            check("stall_op", op, REG_NOP);
            check("stall_rsp_valid", rsp_valid, 0);
            tick();
        end
        dbg_gnt = 1;
        tick();
        check("stall_exec_rsp_valid", rsp_valid, 0);
        tick();
        check("stall_resp_rsp_valid", rsp_valid, 1);
        wait_drain();

        // Dump with write/index fields that must be ignored
        w0 = write_cnt;
        issue(1, 1, 2, 8'hEE);
        exp_q.push_back('{2'd0, 8'h11, 1'b0});
        exp_q.push_back('{2'd1, 8'h22, 1'b0});
        exp_q.push_back('{2'd2, 8'h33, 1'b0});
        exp_q.push_back('{2'd3, 8'h44, 1'b1});
        wait_drain();
        check("dump_no_write", write_cnt, w0);

        // Backpressure during dump
        rsp_ready = 0;
        issue(0, 1, 3, 8'h00);
        exp_q.push_back('{2'd0, 8'h11, 1'b0});
        exp_q.push_back('{2'd1, 8'h22, 1'b0});
        exp_q.push_back('{2'd2, 8'h33, 1'b0});
        exp_q.push_back('{2'd3, 8'h44, 1'b1});
        wait_rsp_valid();
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_index", rsp_index, 0);
            check("bp_data", rsp_data, 8'h11);
            check("bp_last", rsp_last, 0);
            check("bp_op", op, REG_NOP);
            tick();
        end
        check("bp_queue_held", exp_q.size(), 4);
        rsp_ready = 1;
        wait_drain();
        check("bp_no_write", write_cnt, w0);

        // Grant drop in EXEC of a write
        issue(1, 0, 3, 8'h5C);
        exp_q.push_back('{2'd3, 8'h5C, 1'b1});
        tick();
        dbg_gnt = 0;
        #1;
        check("drop_op", op, REG_NOP);
        check("drop_dbg_req", dbg_req, 1);
        repeat (3) tick();
        check("drop_no_write", write_cnt, w0);
        dbg_gnt = 1;
        wait_drain();
        check("drop_one_write", write_cnt, w0 + 1);
        issue(0, 0, 3, 8'h00);
        exp_q.push_back('{2'd3, 8'h5C, 1'b1});
        wait_drain();

        // Reset while a response is pending
        rsp_ready = 0;
        w0 = write_cnt;
        issue(0, 0, 1, 8'h00);
        wait_rsp_valid();
        reset = 1;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_dbg_req", dbg_req, 0);
        check("midrst_rsp_last", rsp_last, 0);
        check("midrst_rsp_data", rsp_data, 0);
        tick();
        reset = 0;
        rsp_ready = 1;
        #1;
        check("midrst_cmd_ready", cmd_ready, 1);
        repeat (3) tick();
        check("midrst_idle_req", dbg_req, 0);
        check("midrst_no_write", write_cnt, w0);
        check("total_writes", write_cnt, 6);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_debug_port.md
REG_DEBUG_PORT -- requirements
Module: reg_debug_port

Interface
REQ-001 The block SHALL have parameter DATA_BUS_WIDTH, default 8, giving the register data width.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid is also high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_dump  in  1  read all four registers in turn.
- cmd_index  in  register_sel_e  target register.
- cmd_wdata  in  DATA_BUS_WIDTH  write data.
- rsp_valid  out  1  response offered.
- rsp_ready  in  1  response consumed.
- rsp_index  out  register_sel_e  register the response refers to.
- rsp_data  out  DATA_BUS_WIDTH  read value, or echoed write data.
- rsp_last  out  1  final response of the command.
- dbg_req  out  1  request ownership of the register-file ports.
- dbg_gnt  in  1  ownership granted by the core.
- op  out  registers_op_e  REG_WRITE on a write cycle, REG_NOP otherwise.
- reg_in_sel  out  register_sel_e  write target.
- reg_data_in  out  DATA_BUS_WIDTH  write data.
- reg_1_out_sel  out  register_sel_e  read-port-1 select.
- reg_1_out  in  DATA_BUS_WIDTH  read-port-1 data, combinational from the selected register.

Function
REQ-003 The block SHALL implement the states IDLE, ACQUIRE, EXEC and RESP.
REQ-004 IDLE SHALL behave as follows:
- cmd_ready=1 and dbg_req=0.
- When cmd_valid=1, latch cmd_write, cmd_dump, cmd_index and cmd_wdata, then move to ACQUIRE.
REQ-005 If cmd_dump=1, the block SHALL treat the command as a dump: cmd_write and cmd_index are ignored and the internal index starts at 0.
REQ-006 In ACQUIRE, EXEC and RESP the block SHALL hold cmd_ready=0 and dbg_req=1.
REQ-007 In ACQUIRE the block SHALL move to EXEC on the first cycle dbg_gnt=1.
REQ-008 EXEC SHALL last exactly one cycle:
- If dbg_gnt=0: drive no register access and return to ACQUIRE.
- Write: op=REG_WRITE, reg_in_sel=latched index, reg_data_in=latched data; capture rsp_data=latched data.
- Read or dump: reg_1_out_sel=current index; capture rsp_data=reg_1_out on that edge.
- In all completing cases, capture rsp_index=current index and move to RESP.
REQ-009 Outside an EXEC cycle with dbg_gnt=1, the block SHALL drive op=REG_NOP.
REQ-010 RESP SHALL behave as follows:
- rsp_valid=1, and rsp_index, rsp_data and rsp_last are held stable until rsp_ready=1.
- rsp_last=1 for read and write, and for a dump only at index 3.
REQ-011 On rsp_valid & rsp_ready the block SHALL:
- For a dump with index <3: increment the index and go to EXEC if dbg_gnt=1, else to ACQUIRE.
- Otherwise: go to IDLE, with dbg_req=0 from the next cycle.
REQ-012 With dbg_gnt held high, rsp_valid SHALL rise after the 2nd rising edge following the accepting edge.
REQ-013 Dump indices SHALL run 0,1,2,3 with no wrap; exactly four responses are produced.
REQ-014 A write SHALL become visible in the register file at the EXEC edge, so a following read of the same index returns the new value.
REQ-015 The block SHALL issue at most one register-file write per accepted write command, including when dbg_gnt toggles.

Reset
REQ-016 While reset=1, independent of clock, the block SHALL force:
- state=IDLE;
- dbg_req=0, rsp_valid=0, rsp_last=0;
- rsp_data=0 and rsp_index=0;
- the internal index and latched command cleared;
- op=REG_NOP and all select/data outputs 0.
REQ-017 After reset deasserts, cmd_ready SHALL be 1; a command in flight at reset is discarded without a register write.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Write then read: dbg_gnt=1; write idx2=0xA5, then read idx2 -> write response rsp_data=0xA5, rsp_last=1; read response rsp_index=2, rsp_data=0xA5.
- Grant stall: read issued with dbg_gnt=0 for 5 cycles -> dbg_req=1 throughout, op=REG_NOP, rsp_valid=0; after dbg_gnt rises, response arrives 2 edges later.
- Dump: registers preloaded 0x11/0x22/0x33/0x44 -> four responses, indices 0..3, matching data, rsp_last only on the 4th.
- Backpressure: rsp_ready=0 for 4 cycles during a dump -> response held stable, no index advance, no extra register activity.
- Grant drop: dbg_gnt drops in EXEC of a write -> no REG_WRITE that cycle; exactly one write occurs after re-grant.
- Mid-command reset: reset asserted in RESP -> rsp_valid and dbg_req fall immediately; cmd_ready=1 after release.
